// File: rtl/oqpsk_pkg.sv
// rtl/oqpsk_pkg.sv - shared constants, types and half-sine table function for the O-QPSK modulator
// Contents:
//   SPC_DEF/DW_DEF/AMP_DEF  default samples/chip, sample width, peak magnitude
//   iq_sample_t             signed I/Q sample at the default width
//   rail_e                  rail selector for the boundary-slot toggle
//   hs_lut(n, spc, amp)     round(amp*sin(pi*n/(2*spc))), elaboration-time only
package oqpsk_pkg;

  localparam int SPC_DEF = 8;
  localparam int DW_DEF  = 4;
  localparam int AMP_DEF = 7;

  localparam real PI = 3.14159265358979;

  typedef logic signed [DW_DEF-1:0] iq_sample_t;

  typedef enum logic {
    RAIL_I = 1'b0,
    RAIL_Q = 1'b1
  } rail_e;

  // Only ever called with constant arguments to build a table, so the real
  // arithmetic folds away. The sine is non-negative over 0..2*spc-1, so
  // adding 0.5 before truncation gives round-to-nearest.
  function automatic int hs_lut(input int n, input int spc, input int amp);
    real x;
    x = real'(amp) * $sin(PI * real'(n) / real'(2 * spc));
    return $rtoi(x + 0.5);
  endfunction

endpackage

// File: rtl/oqpsk_pulse_rail.sv
// rtl/oqpsk_pulse_rail.sv - one half-sine pulse generator rail (used for I and for Q)
// Ports:
//   clk, rst      sample clock, asynchronous active-high reset
//   start         begin a new 2*SPC-sample pulse (may land on the last sample of the previous one)
//   start_zero    the new pulse is all-zero (underrun slot)
//   start_neg     the new pulse is negated (chip 0)
//   active        a pulse (including a zero pulse) is in flight
//   next_sample   undelayed sample the rail shows in the following cycle
module oqpsk_pulse_rail
  import oqpsk_pkg::*;
#(
  parameter int SPC = SPC_DEF,
  parameter int DW  = DW_DEF,
  parameter int AMP = AMP_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 start_zero,
  input  logic                 start_neg,
  output logic                 active,
  output logic signed [DW-1:0] next_sample
);

  localparam int LEN = 2 * SPC;
  localparam int CW  = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic signed [DW-1:0] lut [LEN];

  for (genvar g = 0; g < LEN; g++) begin : g_lut
    assign lut[g] = DW'(hs_lut(g, SPC, AMP));
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          neg_q, neg_d;
  logic          zero_q, zero_d;

  // cnt_q is the index of the sample currently on the undelayed rail.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    if (start) begin
      cnt_d    = '0;
      active_d = 1'b1;
      neg_d    = start_neg;
      zero_d   = start_zero;
    end else if (active_q) begin
      if (cnt_q == LAST) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Look ahead one cycle so the delay line can take a zero-delay tap
  // without an extra register stage.
  always_comb begin
    next_sample = '0;
    if (active_d && !zero_d) begin
      next_sample = neg_d ? -lut[cnt_d] : lut[cnt_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
    end
  end

  assign active = active_q;

endmodule

// File: rtl/oqpsk_iq_modulator.sv
// rtl/oqpsk_iq_modulator.sv - O-QPSK half-sine chip modulator with programmable output delay
// Ports:
//   clk, rst      16 MHz sample clock, asynchronous active-high reset
//   enable        accept chips at chip boundaries; when low, drain then idle
//   chip_in       chip value (1 -> +pulse, 0 -> -pulse), qualified by chip_valid
//   chip_valid    chip_in is valid
//   chip_ready    high in a boundary cycle while enabled
//   tau_in        output delay in samples, 0..7
//   I_out, Q_out  registered signed samples
//   busy          pulse in flight or delay line / outputs still non-zero
//   underrun      one-cycle strobe: enabled boundary without a valid chip
module oqpsk_iq_modulator
  import oqpsk_pkg::*;
#(
  parameter int SPC = SPC_DEF,
  parameter int DW  = DW_DEF,
  parameter int AMP = AMP_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 chip_in,
  input  logic                 chip_valid,
  output logic                 chip_ready,
  input  logic [2:0]           tau_in,
  output logic signed [DW-1:0] I_out,
  output logic signed [DW-1:0] Q_out,
  output logic                 busy,
  output logic                 underrun
);

  localparam int PW    = $clog2(SPC);
  // Seven shift stages plus the output register give taps for 0..7 samples.
  localparam int DEPTH = 7;
  localparam logic [PW-1:0] PH_LAST = PW'(SPC - 1);

  logic [PW-1:0] phase_q, phase_d;
  rail_e         rail_q, rail_d;

  logic boundary;
  logic slot;
  logic start_i, start_q;
  logic active_i, active_q;
  logic signed [DW-1:0] next_i, next_q;

  logic signed [DW-1:0] dly_i_q [DEPTH];
  logic signed [DW-1:0] dly_i_d [DEPTH];
  logic signed [DW-1:0] dly_q_q [DEPTH];
  logic signed [DW-1:0] dly_q_d [DEPTH];
  logic signed [DW-1:0] i_out_q, i_out_d;
  logic signed [DW-1:0] q_out_q, q_out_d;
  logic                 line_nz;

  assign boundary = (phase_q == PH_LAST);
  assign slot     = enable & boundary;
  assign start_i  = slot & (rail_q == RAIL_I);
  assign start_q  = slot & (rail_q == RAIL_Q);

  oqpsk_pulse_rail #(.SPC(SPC), .DW(DW), .AMP(AMP)) u_rail_i (
    .clk         (clk),
    .rst         (rst),
    .start       (start_i),
    .start_zero  (~chip_valid),
    .start_neg   (~chip_in),
    .active      (active_i),
    .next_sample (next_i)
  );

  oqpsk_pulse_rail #(.SPC(SPC), .DW(DW), .AMP(AMP)) u_rail_q (
    .clk         (clk),
    .rst         (rst),
    .start       (start_q),
    .start_zero  (~chip_valid),
    .start_neg   (~chip_in),
    .active      (active_q),
    .next_sample (next_q)
  );

  // The phase keeps running while draining so the delay line empties; it
  // freezes only once everything is quiet and enable is low.
  always_comb begin
    phase_d = phase_q;
    rail_d  = rail_q;
    if (enable || busy) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end
    if (slot) begin
      rail_d = (rail_q == RAIL_I) ? RAIL_Q : RAIL_I;
    end
  end

  // dly_x_q[k] holds the undelayed rail sample from k cycles ago, so the
  // registered output at delay tau is loaded from stage tau-1 (or the
  // rail look-ahead for tau=0).
  always_comb begin
    dly_i_d[0] = next_i;
    dly_q_d[0] = next_q;
    for (int k = 1; k < DEPTH; k++) begin
      dly_i_d[k] = dly_i_q[k-1];
      dly_q_d[k] = dly_q_q[k-1];
    end
    if (tau_in == 3'd0) begin
      i_out_d = next_i;
      q_out_d = next_q;
    end else begin
      i_out_d = dly_i_q[tau_in - 3'd1];
      q_out_d = dly_q_q[tau_in - 3'd1];
    end
  end

  always_comb begin
    line_nz = (i_out_q != '0) || (q_out_q != '0);
    for (int k = 0; k < DEPTH; k++) begin
      line_nz = line_nz || (dly_i_q[k] != '0) || (dly_q_q[k] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_LAST;
      rail_q  <= RAIL_I;
      i_out_q <= '0;
      q_out_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dly_i_q[k] <= '0;
        dly_q_q[k] <= '0;
      end
    end else begin
      phase_q <= phase_d;
      rail_q  <= rail_d;
      i_out_q <= i_out_d;
      q_out_q <= q_out_d;
      for (int k = 0; k < DEPTH; k++) begin
        dly_i_q[k] <= dly_i_d[k];
        dly_q_q[k] <= dly_q_d[k];
      end
    end
  end

  // Reset holds phase at the boundary, so the handshake strobes are masked
  // by rst to keep them low while reset is asserted.
  assign chip_ready = slot & ~rst;
  assign underrun   = slot & ~chip_valid & ~rst;
  assign busy       = active_i | active_q | line_nz;
  assign I_out      = i_out_q;
  assign Q_out      = q_out_q;

endmodule
